// File: rtl/hazard_tnew_pipe.sv
// hazard_tnew_pipe
//   Producer side of the D-stage hazard check. Carries each in-flight
//   instruction's destination register (A3) and remaining-cycles-until-result
//   count (Tnew) down the E, M and W stages. The stall comparator reads these
//   values and returns its stall verdict, which this block turns into a
//   bubble in E. The block also provides forwarding-ready flags and two
//   saturating performance counters.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   stall             D-stage stall verdict (bubble into E, counted)
//   E_clr             flush of E (bubble into E)
//   D_GRF_A3, D_Tnew  destination register and Tnew of the D instruction
//   {E,M,W}_GRF_A3    destination register held in each stage
//   {E,M,W}_Tnew      remaining cycles until that stage's result is ready
//   {E,M,W}_fwd_ok    stage holds a real write whose result is ready now
//   stall_cnt         count of edges with stall=1, saturating
//   bubble_cnt        count of bubbles inserted into E, saturating
module hazard_tnew_pipe #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TNEW_LOAD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             E_clr,
    input  logic [4:0]       D_GRF_A3,
    input  logic [1:0]       D_Tnew,
    output logic [4:0]       E_GRF_A3,
    output logic [4:0]       M_GRF_A3,
    output logic [4:0]       W_GRF_A3,
    output logic [1:0]       E_Tnew,
    output logic [1:0]       M_Tnew,
    output logic [1:0]       W_Tnew,
    output logic             E_fwd_ok,
    output logic             M_fwd_ok,
    output logic             W_fwd_ok,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0] LP_TNEW_LOAD = 2'(TNEW_LOAD);

    logic [4:0]       r_e_a3, r_m_a3, r_w_a3;
    logic [1:0]       r_e_tnew, r_m_tnew, r_w_tnew;
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

    logic             w_bubble;
    logic [1:0]       w_d_tnew;
    logic [1:0]       w_e_tnew_dec;
    logic [1:0]       w_m_tnew_dec;

    always_comb begin
        w_bubble = stall | E_clr;
        // Clamp to the load-class value; a write to $0 never produces a result.
        if (D_GRF_A3 == 5'd0)
            w_d_tnew = 2'd0;
        else if (D_Tnew > LP_TNEW_LOAD)
            w_d_tnew = LP_TNEW_LOAD;
        else
            w_d_tnew = D_Tnew;
        w_e_tnew_dec = (r_e_tnew != 2'd0) ? r_e_tnew - 2'd1 : 2'd0;
        w_m_tnew_dec = (r_m_tnew != 2'd0) ? r_m_tnew - 2'd1 : 2'd0;
    end

    // E/M/W always advance; a stall only affects what enters E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_a3   <= '0;
            r_m_a3   <= '0;
            r_w_a3   <= '0;
            r_e_tnew <= '0;
            r_m_tnew <= '0;
            r_w_tnew <= '0;
        end else begin
            if (w_bubble) begin
                r_e_a3   <= '0;
                r_e_tnew <= '0;
            end else begin
                r_e_a3   <= D_GRF_A3;
                r_e_tnew <= w_d_tnew;
            end
            r_m_a3   <= r_e_a3;
            r_m_tnew <= w_e_tnew_dec;
            r_w_a3   <= r_m_a3;
            r_w_tnew <= w_m_tnew_dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_bubble && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign E_GRF_A3   = r_e_a3;
    assign M_GRF_A3   = r_m_a3;
    assign W_GRF_A3   = r_w_a3;
    assign E_Tnew     = r_e_tnew;
    assign M_Tnew     = r_m_tnew;
    assign W_Tnew     = r_w_tnew;
    assign E_fwd_ok   = (r_e_a3 != 5'd0) && (r_e_tnew == 2'd0);
    assign M_fwd_ok   = (r_m_a3 != 5'd0) && (r_m_tnew == 2'd0);
    assign W_fwd_ok   = (r_w_a3 != 5'd0) && (r_w_tnew == 2'd0);
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
